// File: rtl/alu_seq_pkg.sv
// Shared operation codes for the execute-stage ALU.
// Codes 13..15 select the iterative multiply/divide path.
package definitions;

   typedef enum logic [3:0] {
      OP_ADDU = 4'd0,
      OP_SUBU = 4'd1,
      OP_SLLV = 4'd2,
      OP_SRLV = 4'd3,
      OP_SRAV = 4'd4,
      OP_AND  = 4'd5,
      OP_OR   = 4'd6,
      OP_XOR  = 4'd7,
      OP_NOR  = 4'd8,
      OP_ROL  = 4'd9,
      OP_ROR  = 4'd10,
      OP_SLT  = 4'd11,
      OP_SLTU = 4'd12,
      OP_MULU = 4'd13,
      OP_DIVU = 4'd14,
      OP_REMU = 4'd15
   } alu_seq_op_e;

   function automatic logic is_multi(alu_seq_op_e op);
      return op inside {OP_MULU, OP_DIVU, OP_REMU};
   endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiply / restoring divide datapath.
// One add or subtract per step over a 2*WIDTH accumulator.
module alu_seq_iter
   import definitions::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               div_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic [2*WIDTH-1:0] acc_next_o
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               div_q, div_d;
   logic [WIDTH:0]     op1;
   logic [WIDTH+1:0]   opx;
   logic [WIDTH+1:0]   sum;

   always_comb begin
      op1 = div_q ? acc_q[2*WIDTH-1:WIDTH-1]
                  : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      opx = {2'b00, opnd_q};
      // Subtract as add of the complement; bit WIDTH+1 is the borrow
      sum = {1'b0, op1} + (div_q ? ~opx : opx)
          + {{(WIDTH+1){1'b0}}, div_q};
   end

   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      div_d  = div_q;
      if (load_i) begin
         acc_d  = {{WIDTH{1'b0}}, a_i};
         opnd_d = b_i;
         div_d  = div_i;
      end else if (step_i) begin
         if (div_q) begin
            if (!sum[WIDTH+1])
               acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
         end else begin
            if (acc_q[0])
               acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
            else
               acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         div_q  <= div_d;
      end
   end

   assign acc_next_o = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle ops plus
// iterative unsigned multiply, divide and remainder.
module alu_seq
   import definitions::*;
#(
   parameter int WIDTH = 32,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  alu_seq_op_e      op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } alu_seq_state_e;

   localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   alu_seq_state_e   state_q, state_d;
   logic [SHW:0]     cnt_q, cnt_d;
   alu_seq_op_e      op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;

   logic               accept;
   logic               load;
   logic               step;
   logic [2*WIDTH-1:0] acc_next;
   logic [SHW-1:0]     sh;
   logic [SHW-1:0]     nsh;
   logic [WIDTH-1:0]   sc_res;

   assign accept = valid_i && ready_q;
   assign sh     = b_i[SHW-1:0];
   // Left rotate by n is a right rotate by -n mod WIDTH
   assign nsh    = -sh;

   always_comb begin
      sc_res = '0;
      unique case (op_i)
         OP_ADDU: sc_res = a_i + b_i;
         OP_SUBU: sc_res = a_i - b_i;
         OP_SLLV: sc_res = a_i << sh;
         OP_SRLV: sc_res = a_i >> sh;
         OP_SRAV: sc_res = $signed(a_i) >>> sh;
         OP_AND:  sc_res = a_i & b_i;
         OP_OR:   sc_res = a_i | b_i;
         OP_XOR:  sc_res = a_i ^ b_i;
         OP_NOR:  sc_res = ~(a_i | b_i);
         OP_ROL:  sc_res = WIDTH'({a_i, a_i} >> nsh);
         OP_ROR:  sc_res = WIDTH'({a_i, a_i} >> sh);
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                            $signed(a_i) < $signed(b_i)};
         OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, a_i < b_i};
         default: sc_res = '0;
      endcase
   end

   alu_seq_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load),
      .step_i     (step),
      .div_i      (op_i != OP_MULU),
      .a_i        (a_i),
      .b_i        (b_i),
      .acc_next_o (acc_next)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      result_d = result_q;
      hi_d     = hi_q;
      load     = 1'b0;
      step     = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (accept) begin
               op_d = op_i;
               if (is_multi(op_i)) begin
                  load    = 1'b1;
                  cnt_d   = CNT_INIT;
                  state_d = S_BUSY;
               end else begin
                  result_d = sc_res;
                  hi_d     = '0;
                  state_d  = S_DONE;
               end
            end
         end
         S_BUSY: begin
            step  = 1'b1;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_DONE;
               if (op_q == OP_REMU) begin
                  result_d = acc_next[2*WIDTH-1:WIDTH];
                  hi_d     = acc_next[WIDTH-1:0];
               end else begin
                  result_d = acc_next[WIDTH-1:0];
                  hi_d     = acc_next[2*WIDTH-1:WIDTH];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      valid_d = (state_d == S_DONE);
      busy_d  = (state_d == S_BUSY);
      ready_d = (state_d != S_BUSY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= OP_ADDU;
         result_q <= '0;
         hi_q     <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         result_q <= result_d;
         hi_q     <= hi_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
      end
   end

   assign ready_o  = ready_q;
   assign valid_o  = valid_q;
   assign busy_o   = busy_q;
   assign result_o = result_q;
   assign hi_o     = hi_q;

endmodule

// File: tb/tb_alu_seq.sv
// Random and directed checks of alu_seq against an arithmetic model.
module tb_alu_seq;
   import definitions::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_i = 1'b0;
   alu_seq_op_e op_i = OP_ADDU;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic        ready_o, valid_o, busy_o;
   logic [31:0] result_o, hi_o;

   int checks = 0;
   int failures = 0;

   alu_seq #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (valid_i),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .result_o (result_o),
      .hi_o     (hi_o),
      .busy_o   (busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Returns {hi, result}
   function automatic logic [63:0] model(alu_seq_op_e op,
                                         logic [31:0] a, logic [31:0] b);
      logic [31:0] x;
      logic [63:0] p;
      int amt;
      amt = int'(b[4:0]);
      x = a;
      case (op)
         OP_ADDU: return {32'h0, a + b};
         OP_SUBU: return {32'h0, a - b};
         OP_SLLV: return {32'h0, a << amt};
         OP_SRLV: return {32'h0, a >> amt};
         OP_SRAV: return {32'h0, 32'($signed(a) >>> amt)};
         OP_AND:  return {32'h0, a & b};
         OP_OR:   return {32'h0, a | b};
         OP_XOR:  return {32'h0, a ^ b};
         OP_NOR:  return {32'h0, ~(a | b)};
         OP_ROL: begin
            for (int i = 0; i < amt; i++) x = {x[30:0], x[31]};
            return {32'h0, x};
         end
         OP_ROR: begin
            for (int i = 0; i < amt; i++) x = {x[0], x[31:1]};
            return {32'h0, x};
         end
         OP_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
         OP_SLTU: return (a < b) ? 64'd1 : 64'd0;
         OP_MULU: begin
            p = {32'h0, a} * {32'h0, b};
            return p;
         end
         OP_DIVU:
            return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         OP_REMU:
            return (b == 0) ? {32'hFFFF_FFFF, a} : {a / b, a % b};
         default: return 64'h0;
      endcase
   endfunction

   function automatic int model_lat(alu_seq_op_e op);
      return (op == OP_MULU || op == OP_DIVU || op == OP_REMU) ? 33 : 1;
   endfunction

   task automatic do_op(input string tag, input alu_seq_op_e op,
                        input logic [31:0] a, input logic [31:0] b);
      int n;
      int bc;
      logic [63:0] exp;
      exp = model(op, a, b);
      @(negedge clk);
      chk({tag, ".ready"}, {63'h0, ready_o}, 64'd1);
      valid_i = 1'b1;
      op_i = op;
      a_i = a;
      b_i = b;
      @(posedge clk);
      #1 valid_i = 1'b0;
      bc = 0;
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (valid_o) break;
         if (busy_o) bc++;
      end
      chk({tag, ".lat"}, 64'(n), 64'(model_lat(op)));
      chk({tag, ".res"}, {hi_o, result_o}, exp);
      if (model_lat(op) > 1)
         chk({tag, ".busy"}, 64'(bc), 64'd32);
   endtask

   initial begin
      int pulses;
      int n;
      alu_seq_op_e rop;
      logic [31:0] ra, rb;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.ready", {63'h0, ready_o}, 64'd1);
      chk("rst.valid", {63'h0, valid_o}, 64'd0);
      chk("rst.busy", {63'h0, busy_o}, 64'd0);
      chk("rst.out", {hi_o, result_o}, 64'd0);
      reset = 1'b0;

      // Back-to-back single-cycle ops, second issued in DONE
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_ADDU; a_i = 32'hFFFF_FFFF; b_i = 32'h1;
      @(negedge clk);
      chk("b2b.v1", {63'h0, valid_o}, 64'd1);
      chk("b2b.r1", {hi_o, result_o}, 64'd0);
      chk("b2b.rdy", {63'h0, ready_o}, 64'd1);
      op_i = OP_SUBU; a_i = 32'h0; b_i = 32'h1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("b2b.v2", {63'h0, valid_o}, 64'd1);
      chk("b2b.r2", {hi_o, result_o}, 64'h0000_0000_FFFF_FFFF);
      @(negedge clk);
      chk("b2b.idle", {63'h0, valid_o}, 64'd0);

      do_op("rol", OP_ROL, 32'h8000_0001, 32'd4);
      chk("rol.k", {32'h0, result_o}, 64'h18);
      do_op("ror", OP_ROR, 32'h8000_0001, 32'd1);
      chk("ror.k", {32'h0, result_o}, 64'hC000_0000);
      do_op("ror0", OP_ROR, 32'h8000_0001, 32'd32);
      chk("ror0.k", {32'h0, result_o}, 64'h8000_0001);
      do_op("srav", OP_SRAV, 32'h8000_0000, 32'd31);
      chk("srav.k", {32'h0, result_o}, 64'hFFFF_FFFF);
      do_op("mulu", OP_MULU, 32'hFFFF_FFFF, 32'h2);
      chk("mulu.k", {hi_o, result_o}, 64'h1_FFFF_FFFE);
      do_op("divu", OP_DIVU, 32'd100, 32'd7);
      chk("divu.k", {hi_o, result_o}, {32'd2, 32'd14});
      do_op("remu", OP_REMU, 32'd100, 32'd7);
      chk("remu.k", {hi_o, result_o}, {32'd14, 32'd2});
      do_op("div0", OP_DIVU, 32'd5, 32'd0);
      chk("div0.k", {hi_o, result_o}, {32'd5, 32'hFFFF_FFFF});

      // Reset in cycle 10 of a multiply
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_MULU; a_i = 32'h1234_5678; b_i = 32'h9;
      @(posedge clk);
      #1 valid_i = 1'b0;
      repeat (9) @(negedge clk);
      chk("rmid.busy", {63'h0, busy_o}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rmid.ready", {63'h0, ready_o}, 64'd1);
      chk("rmid.bz", {63'h0, busy_o}, 64'd0);
      chk("rmid.out", {hi_o, result_o}, 64'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid_o) pulses++;
      end
      chk("rmid.pulses", 64'(pulses), 64'd0);

      // Request held during a divide
      @(negedge clk);
      valid_i = 1'b1; op_i = OP_DIVU; a_i = 32'd100; b_i = 32'd7;
      @(posedge clk);
      #1 op_i = OP_ADDU; a_i = 32'd3; b_i = 32'd4;
      for (n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (valid_o) break;
         if (ready_o) chk("hold.rdy", {63'h0, ready_o}, 64'd0);
      end
      chk("hold.lat", 64'(n), 64'd33);
      chk("hold.div", {hi_o, result_o}, {32'd2, 32'd14});
      @(negedge clk);
      valid_i = 1'b0;
      chk("hold.v", {63'h0, valid_o}, 64'd1);
      chk("hold.add", {hi_o, result_o}, 64'd7);

      for (int i = 0; i < 150; i++) begin
         rop = alu_seq_op_e'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 9);
         do_op($sformatf("rnd%0d", i), rop, ra, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the core's combinational ALU. It keeps the single-cycle integer operations (add/sub, shifts, logic, rotates, set-less-than) and adds iterative unsigned multiply, divide and remainder behind a valid/ready handshake. It sits in the execute stage. The core stalls on `ready_o` low and captures results on the `valid_o` pulse.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived; not overridden).

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `valid_i`, in, 1, request valid.
- `op_i`, in, 4, `alu_seq_op_e` operation code.
- `a_i`, in, WIDTH, operand A (rd side).
- `b_i`, in, WIDTH, operand B (rs side).
- `ready_o`, out, 1, block can accept a request this cycle.
- `valid_o`, out, 1, one-cycle pulse; `result_o` and `hi_o` are valid.
- `result_o`, out, WIDTH, primary result: low product, quotient, or single-cycle result.
- `hi_o`, out, WIDTH, high product or remainder; 0 for single-cycle ops.
- `busy_o`, out, 1, multi-cycle operation in progress.

## Operation
- **Accept rule:** a request is accepted when `valid_i && ready_o`. Operands and op are latched on that edge.
- **States:** IDLE, BUSY, DONE. `ready_o` = (IDLE or DONE). `busy_o` = BUSY.
- **Single-cycle ops:** IDLE/DONE → DONE.
  - ADDU, SUBU, AND, OR, XOR, NOR.
  - SLLV, SRLV, SRAV: shift amount is `b[SHW-1:0]`.
  - ROL, ROR: amount is `b[SHW-1:0]`; amount 0 returns A unchanged.
  - SLT (signed), SLTU: result is 1 or 0.
- **MULU:** unsigned shift-add over 2·WIDTH bits. IDLE/DONE → BUSY for WIDTH iterations → DONE.
  - `result_o` = low half of the product; `hi_o` = high half.
- **DIVU/REMU:** restoring division over WIDTH iterations; the path is the same for both.
  - DIVU: `result_o` = quotient, `hi_o` = remainder.
  - REMU: `result_o` = remainder, `hi_o` = quotient.
- **Divide by zero:** quotient = all ones, remainder = A. Takes the full WIDTH iterations, no early exit.
- **Unused op codes:** treated as single-cycle; result 0, hi 0.
- **Arithmetic:** all arithmetic wraps modulo 2^WIDTH. No overflow flag.
- **DONE:** asserts `valid_o` for one cycle, then returns to IDLE unless a new request is accepted in the same cycle.
- **Back-pressure:** none on the output. The consumer must take the result on the `valid_o` pulse.
- **Holding:** `result_o` and `hi_o` hold their last values until the next DONE.
- **While BUSY:** `valid_i` is ignored; the request is neither queued nor dropped silently — the requester must hold it.

## Timing
- **Reset values:** state = IDLE, `ready_o` = 1, `valid_o` = 0, `busy_o` = 0, `result_o` = 0, `hi_o` = 0, iteration counter = 0.
- **Single-cycle latency:** accept at edge N; `valid_o` high in cycle N+1.
- **Multi-cycle latency:** accept at edge N; BUSY for cycles N+1 … N+WIDTH; `valid_o` high in cycle N+WIDTH+1.
- **Throughput:** one single-cycle op per cycle. This is possible because a new accept is allowed in DONE.
- **Iteration counter:** SHW+1 bits, loaded with WIDTH on accept, decrements in BUSY. BUSY → DONE when it reaches 1.
- **Reset mid-operation:** reset in any state aborts the operation. The next cycle shows reset values, and no `valid_o` pulse is ever produced for the aborted op.
- **Reset priority:** reset wins over a simultaneous `valid_i`.

## Structure
- **Package `definitions`:** add `alu_seq_op_e`, a 4-bit enum with codes ADDU, SUBU, SLLV, SRLV, SRAV, AND, OR, XOR, NOR, ROL, ROR, SLT, SLTU, MULU, DIVU, REMU.
- **Local to the block:** the `alu_seq_state_e` enum (IDLE/BUSY/DONE).
- **Sub-module `alu_seq_iter`:** the shared multiply/divide datapath.
  - Contains the 2·WIDTH-bit accumulator/remainder register, operand register, and one add/subtract per cycle.
  - Controlled by a mode bit and a step strobe.
- **Top level:** the FSM, the single-cycle combinational ops, and the output registers.

## Test plan
All scenarios use WIDTH=32.
1. **ADDU wrap:** ADDU 0xFFFFFFFF + 0x1 accepted at edge N → `valid_o` in N+1, `result_o` = 0, `hi_o` = 0. Issue SUBU 0 − 1 in the DONE cycle → `result_o` = 0xFFFFFFFF one cycle later.
2. **Rotates:**
   - ROL a=0x80000001, b=4 → 0x00000018.
   - ROR a=0x80000001, b=1 → 0xC0000000.
   - ROR with b=32 (amount 0) → 0x80000001.
   - SRAV a=0x80000000, b=31 → 0xFFFFFFFF.
3. **MULU:** 0xFFFFFFFF × 0x2 → `result_o` = 0xFFFFFFFE, `hi_o` = 0x1. `valid_o` comes exactly 33 cycles after accept, and `busy_o` is high for 32 cycles.
4. **Divide:**
   - DIVU 100 / 7 → `result_o` = 14, `hi_o` = 2.
   - REMU 100 / 7 → `result_o` = 2, `hi_o` = 14.
   - DIVU 5 / 0 → `result_o` = 0xFFFFFFFF, `hi_o` = 5, at the same 33-cycle latency.
5. **Reset mid-op:** assert reset in cycle 10 of a MULU → next cycle `ready_o` = 1, `result_o` = 0, `busy_o` = 0. No `valid_o` pulse occurs in the following 40 cycles.
6. **Request while BUSY:** hold `valid_i` with ADDU 3+4 during a DIVU → ignored until DONE. It is accepted in the DONE cycle, and `result_o` = 7 appears the cycle after the divide's `valid_o`.
